// File: rtl/demux2_serial_receiver.sv
// Receiving end of the 2:1 shared-line mux path: steers each valid serial bit to one of
// two deserializers, each with its own valid/ready word output and sticky overrun flag.
module demux2_serial_receiver #(
    parameter int WIDTH     = 8,
    parameter bit INVERT_IN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             sel,
    output logic [WIDTH-1:0] data0,
    output logic             valid0,
    input  logic             ready0,
    output logic             overrun0,
    output logic [WIDTH-1:0] data1,
    output logic             valid1,
    input  logic             ready1,
    output logic             overrun1
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic       d;
    logic [1:0] ready;

    assign d     = bit_in ^ INVERT_IN;
    assign ready = {ready1, ready0};

    genvar c;
    generate
        for (c = 0; c < 2; c++) begin : g_ch
            logic [WIDTH-1:0] sr;
            logic [CNT_W-1:0] cnt;
            logic [WIDTH-1:0] data_p1;
            logic             vld_p1;
            logic             ovr;
            logic             take;
            logic             done;
            logic             slot_free;
            logic [WIDTH-1:0] word;

            assign take      = bit_valid && (sel == 1'(c));
            assign done      = take && (cnt == LAST);
            assign word      = {sr[WIDTH-2:0], d};
            assign slot_free = !vld_p1 || ready[c];

            // Shift stage feeds the output register stage (_p1)
            always_ff @(posedge clk) begin
                if (rst) begin
                    sr      <= '0;
                    cnt     <= '0;
                    data_p1 <= '0;
                    vld_p1  <= 1'b0;
                    ovr     <= 1'b0;
                end else begin
                    if (take) begin
                        sr  <= word;
                        cnt <= done ? '0 : cnt + 1'b1;
                    end
                    if (done && slot_free) begin
                        data_p1 <= word;
                        vld_p1  <= 1'b1;
                    end else if (vld_p1 && ready[c]) begin
                        vld_p1 <= 1'b0;
                    end
                    if (done && !slot_free) begin
                        ovr <= 1'b1;
                    end
                end
            end
        end
    endgenerate

    assign data0    = g_ch[0].data_p1;
    assign valid0   = g_ch[0].vld_p1;
    assign overrun0 = g_ch[0].ovr;
    assign data1    = g_ch[1].data_p1;
    assign valid1   = g_ch[1].vld_p1;
    assign overrun1 = g_ch[1].ovr;

endmodule

// File: tb/tb_demux2_serial_receiver.sv
// Bench for demux2_serial_receiver: vector table plus hand-written corner sequences,
// with per-channel expected-word queues checked whenever a word is handed off.
module tb_demux2_serial_receiver;

    logic       clk = 1'b0;
    logic       rst, bit_in, bit_valid, sel, ready0, ready1;
    logic [7:0] data0, data1, r_data0, r_data1;
    logic       valid0, valid1, overrun0, overrun1;
    logic       r_valid0, r_valid1, r_overrun0, r_overrun1;

    int passed = 0;
    int total  = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];

    typedef struct {
        logic       ch;
        logic [7:0] line;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[4];

    always #5 clk = ~clk;

    demux2_serial_receiver #(.WIDTH(8), .INVERT_IN(1'b1)) dut (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .sel(sel),
        .data0(data0), .valid0(valid0), .ready0(ready0), .overrun0(overrun0),
        .data1(data1), .valid1(valid1), .ready1(ready1), .overrun1(overrun1)
    );

    demux2_serial_receiver #(.WIDTH(8), .INVERT_IN(1'b0)) dut_raw (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .sel(sel),
        .data0(r_data0), .valid0(r_valid0), .ready0(ready0), .overrun0(r_overrun0),
        .data1(r_data1), .valid1(r_valid1), .ready1(ready1), .overrun1(r_overrun1)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    task automatic drive_bit(input logic ch, input logic b);
        @(posedge clk); #1;
        bit_valid = 1'b1;
        sel       = ch;
        bit_in    = b;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            bit_valid = 1'b0;
            sel       = 1'bx;
            bit_in    = 1'bx;
        end
    endtask

    task automatic send_word(input logic ch, input logic [7:0] line, input logic [7:0] exp);
        if (ch) q1.push_back(exp);
        else    q0.push_back(exp);
        for (int i = 7; i >= 0; i--) drive_bit(ch, line[i]);
    endtask

    // Scoreboard: a word is handed off on the next edge whenever valid && ready here
    always @(negedge clk) begin
        if (!rst && valid0 && ready0) begin
            if (q0.size() == 0) begin
                total++;
                $display("FAIL sb0_unexpected: got %0h, required no word", data0);
            end else chk("sb0_data", data0, q0.pop_front());
        end
        if (!rst && valid1 && ready1) begin
            if (q1.size() == 0) begin
                total++;
                $display("FAIL sb1_unexpected: got %0h, required no word", data1);
            end else chk("sb1_data", data1, q1.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{ch: 1'b0, line: ~8'hA5, exp: 8'hA5};
        vecs[1] = '{ch: 1'b1, line: ~8'h5A, exp: 8'h5A};
        vecs[2] = '{ch: 1'b0, line: ~8'h00, exp: 8'h00};
        vecs[3] = '{ch: 1'b1, line: ~8'hFF, exp: 8'hFF};

        rst = 1'b1; bit_valid = 1'b0; sel = 1'b0; bit_in = 1'b0;
        ready0 = 1'b1; ready1 = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_data0", data0, 8'h00);
        chk("reset_valid0", valid0, 1'b0);
        chk("reset_overrun0", overrun0, 1'b0);
        chk("reset_data1", data1, 8'h00);
        chk("reset_valid1", valid1, 1'b0);
        chk("reset_overrun1", overrun1, 1'b0);

        // Basic receive: one-cycle valid pulse with ready held high
        send_word(1'b0, ~8'hA5, 8'hA5);
        idle(1);
        @(negedge clk);
        chk("basic_valid0", valid0, 1'b1);
        chk("basic_data0", data0, 8'hA5);
        chk("basic_valid1", valid1, 1'b0);
        @(negedge clk);
        chk("basic_valid0_drop", valid0, 1'b0);
        chk("basic_overrun0", overrun0, 1'b0);
        idle(2);

        for (int v = 0; v < 4; v++) send_word(vecs[v].ch, vecs[v].line, vecs[v].exp);
        idle(3);
        chk("table_q0_empty", q0.size(), 0);
        chk("table_q1_empty", q1.size(), 0);

        // Interleaved channels with X-filled gaps
        q0.push_back(8'h3C);
        q1.push_back(8'hF0);
        begin
            logic [7:0] w0, w1;
            w0 = ~8'h3C;
            w1 = ~8'hF0;
            for (int i = 7; i >= 0; i--) begin
                drive_bit(1'b0, w0[i]);
                if (i % 2 == 1) idle(1);
                drive_bit(1'b1, w1[i]);
                if (i == 0) begin
                    @(negedge clk);
                    chk("ilv_valid0", valid0, 1'b1);
                    chk("ilv_data0", data0, 8'h3C);
                end
            end
        end
        idle(1);
        @(negedge clk);
        chk("ilv_valid1", valid1, 1'b1);
        chk("ilv_data1", data1, 8'hF0);
        idle(2);
        chk("ilv_q_empty", q0.size() + q1.size(), 0);

        // Back-pressure and overrun on channel 1
        ready1 = 1'b0;
        send_word(1'b1, ~8'h11, 8'h11);
        idle(1);
        @(negedge clk);
        chk("bp_valid1", valid1, 1'b1);
        chk("bp_data1", data1, 8'h11);
        chk("bp_overrun1_pre", overrun1, 1'b0);
        for (int i = 7; i >= 0; i--) begin
            logic [7:0] w;
            w = ~8'h22;
            drive_bit(1'b1, w[i]);
        end
        idle(1);
        @(negedge clk);
        chk("ovr_data1", data1, 8'h11);
        chk("ovr_valid1", valid1, 1'b1);
        chk("ovr_overrun1", overrun1, 1'b1);
        @(posedge clk); #1 ready1 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("drain_valid1", valid1, 1'b0);
        chk("drain_overrun1_sticky", overrun1, 1'b1);
        idle(2);

        // Completion and drain in the same cycle on channel 0
        ready0 = 1'b0;
        send_word(1'b0, ~8'h55, 8'h55);
        idle(1);
        q0.push_back(8'h66);
        begin
            logic [7:0] w;
            w = ~8'h66;
            for (int i = 7; i >= 1; i--) drive_bit(1'b0, w[i]);
            drive_bit(1'b0, w[0]);
            ready0 = 1'b1;
        end
        idle(1);
        @(negedge clk);
        chk("both_valid0", valid0, 1'b1);
        chk("both_data0", data0, 8'h66);
        chk("both_overrun0", overrun0, 1'b0);
        idle(2);
        chk("both_q0_empty", q0.size(), 0);

        // Reset mid-word discards partial bits
        for (int i = 0; i < 5; i++) drive_bit(1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1; bit_valid = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rstmid_outs", {data0, valid0, overrun0, data1, valid1, overrun1}, 20'h0);
        q0.push_back(8'h81);
        begin
            logic [7:0] w;
            w = ~8'h81;
            for (int i = 7; i >= 0; i--) begin
                drive_bit(1'b0, w[i]);
                if (i == 0) begin
                    @(negedge clk);
                    chk("rstmid_no_early_valid", valid0, 1'b0);
                end
            end
        end
        idle(1);
        @(negedge clk);
        chk("rstmid_valid0", valid0, 1'b1);
        chk("rstmid_data0", data0, 8'h81);
        idle(2);

        // Non-inverting instance receives raw bits on channel 1
        send_word(1'b1, 8'hC3, 8'h3C);
        idle(1);
        @(negedge clk);
        chk("raw_valid1", r_valid1, 1'b1);
        chk("raw_data1", r_data1, 8'hC3);
        chk("raw_overrun1", r_overrun1, 1'b0);
        idle(3);

        chk("final_q0_empty", q0.size(), 0);
        chk("final_q1_empty", q1.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
